// File: rtl/uart_job_protocol.sv
// Host-protocol engine for the miner UART link: parses CRC-checked host frames,
// keeps a current and a queued job, and emits unsolicited nonce/work-status frames.

module uart_job_crc32 (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_en,
  input  logic        i_init,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_crc
);
  logic [31:0] r_crc;

  // Reflected CRC32 with no final XOR: a frame followed by its own CRC (LSB first)
  // drives the register back to zero, which is the receive-side acceptance test.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] v;
    v = c ^ {24'd0, b};
    for (int k = 0; k < 8; k++) v = v[0] ? ((v >> 1) ^ 32'hEDB88320) : (v >> 1);
    return v;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_crc <= 32'hFFFFFFFF;
    else if (i_en) r_crc <= crc_step(i_init ? 32'hFFFFFFFF : r_crc, i_byte);
  end

  assign o_crc = r_crc;
endmodule

module uart_job_protocol #(
  parameter int          JOB_BYTES        = 52,
  parameter int          MSG_BUF_BYTES    = 64,
  parameter int          NONCE_FIFO_DEPTH = 4,
  parameter logic [63:0] INFO_WORD        = 64'hDEADBEEF13370D13,
  parameter int          RX_TIMEOUT       = 65535
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx_flag,
  input  logic [7:0]             rx_byte,
  output logic                   tx_we,
  output logic [7:0]             tx_data,
  input  logic                   tx_busy,
  input  logic                   need_work,
  input  logic                   nonce_valid,
  input  logic [31:0]            nonce,
  output logic                   job_load,
  output logic [JOB_BYTES*8-1:0] job,
  output logic                   job_valid
);
  localparam int JW  = JOB_BYTES * 8;
  localparam int FAW = $clog2(NONCE_FIFO_DEPTH);
  localparam int BIW = $clog2(MSG_BUF_BYTES);
  localparam int TW  = $clog2(RX_TIMEOUT + 1);

  localparam logic [7:0] T_INFO     = 8'd0;
  localparam logic [7:0] T_INVALID  = 8'd1;
  localparam logic [7:0] T_ACK      = 8'd2;
  localparam logic [7:0] T_RESEND   = 8'd3;
  localparam logic [7:0] T_PUSH     = 8'd4;
  localparam logic [7:0] T_QUEUE    = 8'd5;
  localparam logic [7:0] T_NONCE    = 8'd6;
  localparam logic [7:0] T_QSTARTED = 8'd7;
  localparam logic [7:0] T_NEEDWORK = 8'd8;
  localparam logic [7:0] T_RESET    = 8'd9;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_PARSE, S_SEND} state_t;

  state_t        r_state;
  logic [7:0]    r_len;
  logic [7:0]    r_cnt;
  logic [7:0]    r_type;
  logic [TW-1:0] r_tmo;
  logic [7:0]    r_tx_len;
  logic [7:0]    r_tx_type;
  logic [7:0]    r_tx_idx;
  logic [95:0]   r_tx_pl;
  logic [JW-1:0] r_job;
  logic [JW-1:0] r_queue;
  logic          r_job_valid;
  logic          r_job_load;
  logic          r_q_valid;
  logic          r_started_pend;
  logic          r_needwork_pend;
  logic [FAW:0]  r_wr_ptr;
  logic [FAW:0]  r_rd_ptr;
  logic [15:0]   r_drop;
  logic [7:0]    r_buf  [MSG_BUF_BYTES];
  logic [31:0]   r_fifo [NONCE_FIFO_DEPTH];

  logic          w_crc_en;
  logic          w_crc_init;
  logic [31:0]   w_crc;
  logic [JW-1:0] w_buf_job;
  logic          w_store;
  logic [BIW-1:0] w_bidx;
  logic [FAW:0]  w_level;
  logic          w_fifo_nempty;
  logic          w_fifo_full;
  logic [31:0]   w_fifo_head;
  logic          w_push_ok;
  logic          w_go;
  logic [7:0]    w_go_len;
  logic [7:0]    w_go_type;
  logic [95:0]   w_go_pl;
  logic          w_pop;
  logic          w_clr_started;
  logic          w_clr_needwork;
  logic          w_act_push;
  logic          w_act_queue;
  logic          w_act_reset;
  logic [7:0]    w_tx_byte;

  assign w_crc_en   = rx_flag && (r_state == S_IDLE || r_state == S_READ);
  assign w_crc_init = (r_state == S_IDLE);

  uart_job_crc32 u_crc (
    .clk    (clk),
    .reset  (reset),
    .i_en   (w_crc_en),
    .i_init (w_crc_init),
    .i_byte (rx_byte),
    .o_crc  (w_crc)
  );

  // Only payload bytes are kept; header and CRC trailer are counted but not stored.
  assign w_store = (r_cnt >= 8'd4) && (r_cnt < r_len - 8'd4) &&
                   (int'(r_cnt) - 4 < MSG_BUF_BYTES);
  assign w_bidx  = BIW'(r_cnt - 8'd4);

  always_comb begin
    w_buf_job = '0;
    for (int k = 0; k < JOB_BYTES; k++) w_buf_job[8*k +: 8] = r_buf[k];
  end

  assign w_level       = r_wr_ptr - r_rd_ptr;
  assign w_fifo_nempty = (r_wr_ptr != r_rd_ptr);
  assign w_fifo_full   = (r_wr_ptr[FAW] != r_rd_ptr[FAW]) &&
                         (r_wr_ptr[FAW-1:0] == r_rd_ptr[FAW-1:0]);
  assign w_fifo_head   = r_fifo[r_rd_ptr[FAW-1:0]];
  assign w_push_ok     = nonce_valid && (!w_fifo_full || w_pop);

  // Decide what to transmit next; a reply length of 1 makes byte 0 (the length) the PING answer 0x01.
  always_comb begin
    w_go           = 1'b0;
    w_go_len       = 8'd8;
    w_go_type      = T_INVALID;
    w_go_pl        = '0;
    w_pop          = 1'b0;
    w_clr_started  = 1'b0;
    w_clr_needwork = 1'b0;
    w_act_push     = 1'b0;
    w_act_queue    = 1'b0;
    w_act_reset    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (rx_flag) begin
          if (rx_byte == 8'd0) begin
            w_go     = 1'b1;
            w_go_len = 8'd1;
          end else if (rx_byte < 8'd8) begin
            w_go = 1'b1;
          end
        end else if (r_started_pend) begin
          w_go          = 1'b1;
          w_go_type     = T_QSTARTED;
          w_clr_started = 1'b1;
        end else if (w_fifo_nempty) begin
          w_go          = 1'b1;
          w_go_len      = 8'd12;
          w_go_type     = T_NONCE;
          w_go_pl[31:0] = w_fifo_head;
          w_pop         = 1'b1;
        end else if (r_needwork_pend) begin
          w_go           = 1'b1;
          w_go_type      = T_NEEDWORK;
          w_clr_needwork = 1'b1;
        end
      end
      S_PARSE: begin
        w_go = 1'b1;
        if (w_crc != 32'd0) begin
          w_go_type = T_RESEND;
        end else if (int'(r_len) > MSG_BUF_BYTES + 8) begin
          w_go_type = T_INVALID;
        end else if (r_type == T_INFO && r_len == 8'd8) begin
          w_go_len  = 8'd20;
          w_go_type = T_INFO;
          w_go_pl   = {8'(w_level), 7'd0, r_q_valid, r_drop, INFO_WORD};
        end else if (r_type == T_PUSH && int'(r_len) == JOB_BYTES + 8) begin
          w_go_type  = T_ACK;
          w_act_push = 1'b1;
        end else if (r_type == T_QUEUE && int'(r_len) == JOB_BYTES + 8) begin
          w_go_type   = T_ACK;
          w_act_queue = 1'b1;
        end else if (r_type == T_RESET && r_len == 8'd8) begin
          w_go_type   = T_ACK;
          w_act_reset = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    w_tx_byte = 8'd0;
    if (r_tx_idx == 8'd0) w_tx_byte = r_tx_len;
    else if (r_tx_idx == 8'd3) w_tx_byte = r_tx_type;
    else if (r_tx_idx >= 8'd4 && r_tx_idx < r_tx_len - 8'd4)
      w_tx_byte = 8'(r_tx_pl >> {r_tx_idx - 8'd4, 3'b000});
  end

  assign tx_we     = (r_state == S_SEND) && !tx_busy;
  assign tx_data   = w_tx_byte;
  assign job       = r_job;
  assign job_valid = r_job_valid;
  assign job_load  = r_job_load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_len           <= 8'd0;
      r_cnt           <= 8'd0;
      r_type          <= 8'd0;
      r_tmo           <= '0;
      r_tx_len        <= 8'd0;
      r_tx_type       <= 8'd0;
      r_tx_idx        <= 8'd0;
      r_job           <= '0;
      r_job_valid     <= 1'b0;
      r_job_load      <= 1'b0;
      r_q_valid       <= 1'b0;
      r_started_pend  <= 1'b0;
      r_needwork_pend <= 1'b0;
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_drop          <= 16'd0;
    end else begin
      r_job_load <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (rx_flag && rx_byte >= 8'd8) begin
            r_len   <= rx_byte;
            r_cnt   <= 8'd1;
            r_tmo   <= '0;
            r_state <= S_READ;
          end
        end
        S_READ: begin
          if (rx_flag) begin
            r_cnt <= r_cnt + 8'd1;
            r_tmo <= '0;
            if (r_cnt == 8'd3) r_type <= rx_byte;
            if (r_cnt + 8'd1 == r_len) r_state <= S_PARSE;
          end else if (r_tmo == TW'(RX_TIMEOUT - 1)) begin
            r_state <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_SEND: begin
          if (!tx_busy) begin
            r_tx_idx <= r_tx_idx + 8'd1;
            if (r_tx_idx + 8'd1 == r_tx_len) r_state <= S_IDLE;
          end
        end
        default: ;
      endcase

      if (w_go) begin
        r_state   <= S_SEND;
        r_tx_len  <= w_go_len;
        r_tx_type <= w_go_type;
        r_tx_idx  <= 8'd0;
      end

      // Later assignments win: a fresh need_work beats the flag clear, a host command beats need_work.
      if (w_clr_started)  r_started_pend  <= 1'b0;
      if (w_clr_needwork) r_needwork_pend <= 1'b0;
      if (need_work) begin
        if (r_q_valid) begin
          r_job          <= r_queue;
          r_job_valid    <= 1'b1;
          r_q_valid      <= 1'b0;
          r_job_load     <= 1'b1;
          r_started_pend <= 1'b1;
        end else begin
          r_needwork_pend <= 1'b1;
        end
      end
      if (w_act_push) begin
        r_job       <= w_buf_job;
        r_job_valid <= 1'b1;
        r_q_valid   <= 1'b0;
        r_job_load  <= 1'b1;
      end
      if (w_act_queue) r_q_valid <= 1'b1;

      if (w_act_reset) begin
        r_job_valid     <= 1'b0;
        r_q_valid       <= 1'b0;
        r_started_pend  <= 1'b0;
        r_needwork_pend <= 1'b0;
        r_wr_ptr        <= '0;
        r_rd_ptr        <= '0;
      end else begin
        if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
        if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (nonce_valid && !w_push_ok && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_READ && rx_flag && w_store) r_buf[w_bidx] <= rx_byte;
    if (w_act_queue) r_queue <= w_buf_job;
    if (w_push_ok) r_fifo[r_wr_ptr[FAW-1:0]] <= nonce;
    if (w_go) r_tx_pl <= w_go_pl;
  end
endmodule
